sha256_msg_schedule: RTL and testbench
======================================

Name: sha256_msg_schedule

Overview:
Sequential SHA-256 message-schedule generator. Accepts one 512-bit padded block and streams W[0..63] to the compression-round datapath over a valid/ready interface, WORDS_PER_CYCLE words per beat. It uses a 16-word sliding window, so the round logic needs no 64-word store. It sits between the block/nonce assembler and the round core in the mining pipeline.

Parameters:
WORDS_PER_CYCLE, 1, schedule words emitted per beat; legal values 1, 2, 4 (must divide 64); any other value is an elaboration error.
IDX_W, 6, width of the word-index output; fixed by 64 rounds, and any other value is an elaboration error.

Ports:
clk  input  1  clock.
reset  input  1  asynchronous, active-high reset.
in_valid  input  1  in_block is valid.
in_ready  output  1  block can be accepted.
in_block  input  512  padded message block; W[i] = in_block[511-32*i -: 32].
w_valid  output  1  w_data is valid.
w_ready  input  1  consumer accepts the beat.
w_data  output  32*WORDS_PER_CYCLE  lane k (bits [32k+31:32k]) = W[w_index+k].
w_index  output  IDX_W  index of lane 0 word.
w_last  output  1  beat contains W[63].
busy  output  1  a block is being emitted.

Behaviour:
- One clock domain: clk. Reset is asynchronous and active-high (reset).
- Reset: all outputs 0 while reset is asserted (in_ready, w_valid, w_last, busy, w_index, w_data); window cleared; state IDLE. The first cycle after deassertion has in_ready=1.
- State IDLE: in_ready=1, w_valid=0, busy=0.
  - in_valid&in_ready loads window[0..15] = W[0..15], sets t=0, and moves to RUN.
  - Next cycle: w_valid=1.
- State RUN: busy=1, w_valid=1, w_data lanes = window[0..WPC-1], w_index=t.
  - w_valid&w_ready: t+=WPC; window shifts down by WPC; WPC new words are appended at window[16-WPC..15].
  - Stall (w_ready=0): w_data, w_index and w_last held stable; window frozen.
- New word j (0..WPC-1), for target index t+16+j:
  - Formula: sigma1(W[t+14+j]) + W[t+9+j] + sigma0(W[t+1+j]) + W[t+j], mod 2^32.
  - sigma0(x) = ROTR7 ^ ROTR18 ^ SHR3; sigma1(x) = ROTR17 ^ ROTR19 ^ SHR10.
  - For j>=2, the W[t+14+j] operand is the new word j-2 computed in the same cycle (combinational chain).
  - Words computed beyond W[63] are don't-care and are never emitted.
- w_last=1 exactly when w_index == 64-WPC.
  - The handshake on that beat returns to IDLE; w_valid drops the following cycle (no bubble only with the optional feature).
- Latency: first beat valid 1 cycle after input acceptance. Throughput: 64/WPC beats per block with w_ready held high; one idle cycle between blocks in the base configuration.
- in_valid while busy is ignored; the block is not latched and in_ready=0.
- Reset mid-block: immediate abort, no further beats, state IDLE.

Optional Feature:
SHA256_SCHED_DBL_BUF_EN.
- Defined: a 512-bit shadow register plus a shadow-full flag.
  - in_ready = !shadow_full in both states; in RUN, acceptance fills the shadow.
  - On the w_last handshake with shadow full: window loads from the shadow, t=0, state stays RUN. w_valid stays 1 (zero-bubble back-to-back blocks) and the shadow is freed.
  - If the shadow fills on the same cycle as the w_last handshake, that block goes straight to the window.
  - Reset clears the shadow.
- Undefined: no shadow; in_ready only in IDLE as above.

Decomposition:
- Package Definitions:
  - WORD_W=32, BLOCK_WORDS=16, SHA256_ROUNDS=64.
  - typedef word_t (logic[31:0]).
  - Functions sha256_sigma0/sha256_sigma1, shared with the round core.
- One sub-module, sha256_sched_word_calc: combinational, four word_t operands in, one out. Instantiated WPC times and chained per the dependency rule above.

Test Plan:
- WPC=1, "abc" block (W0=0x61626380, W1..14=0, W15=0x00000018), w_ready=1 -> 64 beats: W16=0x61626380, W17=0x000F0000, W18=0x7DA86405, W63=0x12B1EDEB; w_last only on w_index=63.
- WPC=4, same block -> 16 beats; beat 4 lanes = {0x61626380, 0x000F0000, 0x7DA86405, W19}; W19 compared against the golden model.
- Random w_ready backpressure (50%), WPC=2 -> sequence identical to the stall-free run; w_data and w_index stable during every stall.
- reset asserted at beat 20 -> outputs 0 immediately; a next block loaded after deassertion emits from W0 correctly.
- DBL_BUF_EN, two blocks offered back-to-back -> beat with w_index=0 of block 2 directly follows w_last of block 1; w_valid never drops.
- in_valid held during RUN (base config) -> in_ready=0 and output stream unchanged.

Source files
------------

// File: rtl/sha256_msg_schedule_pkg.sv
// sha256_msg_schedule_pkg
//   Shared definitions for the SHA-256 message-schedule generator and the
//   round core: word/block geometry, the schedule sigma functions and a
//   helper that unpacks a 512-bit block into its sixteen big-endian words.
//   No ports (package).
package sha256_msg_schedule_pkg;

    localparam int unsigned WORD_W        = 32;
    localparam int unsigned BLOCK_WORDS   = 16;
    localparam int unsigned SHA256_ROUNDS = 64;
    localparam int unsigned BLOCK_W       = WORD_W * BLOCK_WORDS;

    typedef logic [WORD_W-1:0] word_t;

    // Sixteen-word sliding window; element 0 is the oldest word (lane 0).
    typedef logic [BLOCK_WORDS-1:0][WORD_W-1:0] window_t;

    typedef enum logic [0:0] {
        StIdle,
        StRun
    } sched_state_e;

    function automatic word_t sha256_rotr(input word_t x, input int unsigned n);
        return (x >> n) | (x << (WORD_W - n));
    endfunction

    function automatic word_t sha256_sigma0(input word_t x);
        return sha256_rotr(x, 7) ^ sha256_rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic word_t sha256_sigma1(input word_t x);
        return sha256_rotr(x, 17) ^ sha256_rotr(x, 19) ^ (x >> 10);
    endfunction

    // W[i] sits at the top of the block for i = 0 (big-endian word order).
    function automatic window_t block_to_window(input logic [BLOCK_W-1:0] blk);
        window_t w;
        for (int i = 0; i < BLOCK_WORDS; i++) begin
            w[i] = blk[BLOCK_W - 1 - WORD_W * i -: WORD_W];
        end
        return w;
    endfunction

endpackage

// File: rtl/sha256_sched_word_calc.sv
// sha256_sched_word_calc
//   Combinational SHA-256 schedule expansion for one new word:
//     w_new = sigma1(w14) + w9 + sigma0(w1) + w0   (mod 2^32)
//   Ports:
//     w14, w9, w1, w0 : operands W[t+14], W[t+9], W[t+1], W[t] relative to
//                       the word being produced (W[t+16]).
//     w_new           : the new schedule word.
module sha256_sched_word_calc
    import sha256_msg_schedule_pkg::*;
(
    input  word_t w14,
    input  word_t w9,
    input  word_t w1,
    input  word_t w0,
    output word_t w_new
);

    assign w_new = sha256_sigma1(w14) + w9 + sha256_sigma0(w1) + w0;

endmodule

// File: rtl/sha256_msg_schedule.sv
// sha256_msg_schedule
//   Streams the 64-word SHA-256 message schedule W[0..63] of one padded
//   512-bit block, WORDS_PER_CYCLE words per beat, using a 16-word sliding
//   window instead of a 64-word store.
//   Optional build macro: SHA256_SCHED_DBL_BUF_EN adds a one-block shadow
//   buffer so consecutive blocks stream with no idle cycle between them.
//   Ports:
//     clk, reset           : clock, asynchronous active-high reset.
//     in_valid/in_ready    : block handshake; in_block holds W[0] in its MSBs.
//     w_valid/w_ready      : schedule beat handshake.
//     w_data               : lane k = W[w_index + k].
//     w_index              : index of the lane-0 word.
//     w_last               : beat carries W[63].
//     busy                 : a block is being emitted.
module sha256_msg_schedule
    import sha256_msg_schedule_pkg::*;
#(
    parameter int unsigned WORDS_PER_CYCLE = 1,
    parameter int unsigned IDX_W           = 6
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [BLOCK_W-1:0]                in_block,
    output logic                              w_valid,
    input  logic                              w_ready,
    output logic [WORD_W*WORDS_PER_CYCLE-1:0] w_data,
    output logic [IDX_W-1:0]                  w_index,
    output logic                              w_last,
    output logic                              busy
);

    if (WORDS_PER_CYCLE != 1 && WORDS_PER_CYCLE != 2 && WORDS_PER_CYCLE != 4) begin : gen_bad_wpc
        $error("sha256_msg_schedule: WORDS_PER_CYCLE must be 1, 2 or 4");
    end
    if (IDX_W != 6) begin : gen_bad_idx_w
        $error("sha256_msg_schedule: IDX_W must be 6");
    end

    localparam logic [IDX_W-1:0] STEP     = IDX_W'(WORDS_PER_CYCLE);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SHA256_ROUNDS - WORDS_PER_CYCLE);

    sched_state_e     state_q;
    logic [IDX_W-1:0] t_q;
    window_t          window_q;
    window_t          window_shift;

`ifdef SHA256_SCHED_DBL_BUF_EN
    logic [BLOCK_W-1:0] shadow_q;
    logic               shadow_full_q;
`endif

    logic in_fire;
    logic out_fire;

    // ------------------------------------------------------------------
    // Outputs are pure decodes of the state registers, so reset forces
    // them to zero immediately.
    // ------------------------------------------------------------------
    assign w_valid = (state_q == StRun);
    assign busy    = (state_q == StRun);
    assign w_index = t_q;
    assign w_last  = (state_q == StRun) && (t_q == LAST_IDX);

`ifdef SHA256_SCHED_DBL_BUF_EN
    assign in_ready = !reset && !shadow_full_q;
`else
    assign in_ready = !reset && (state_q == StIdle);
`endif

    assign in_fire  = in_valid && in_ready;
    assign out_fire = w_valid && w_ready;

    for (genvar k = 0; k < WORDS_PER_CYCLE; k++) begin : gen_out_lane
        assign w_data[WORD_W*k +: WORD_W] = window_q[k];
    end

    // ------------------------------------------------------------------
    // New-word generation. Lanes 0/1 read only the window; lanes 2/3 need
    // the word produced two lanes below in the same cycle. The results are
    // split into two vectors so the chained lanes never read the vector
    // they drive (no self-referencing combinational net).
    // ------------------------------------------------------------------
    word_t new_lo [WORDS_PER_CYCLE];
    word_t new_hi [WORDS_PER_CYCLE];

    for (genvar j = 0; j < WORDS_PER_CYCLE; j++) begin : gen_lane
        word_t op14;
        word_t sum;

        if (j < 2) begin : gen_direct
            assign op14      = window_q[14 + j];
            assign new_lo[j] = sum;
            assign new_hi[j] = '0;
        end else begin : gen_chain
            assign op14      = new_lo[j - 2];
            assign new_lo[j] = '0;
            assign new_hi[j] = sum;
        end

        sha256_sched_word_calc u_word_calc (
            .w14   (op14),
            .w9    (window_q[9 + j]),
            .w1    (window_q[1 + j]),
            .w0    (window_q[j]),
            .w_new (sum)
        );
    end

    // Window after one accepted beat: drop WPC oldest words, append new ones.
    always_comb begin
        window_shift = window_q;
        for (int i = 0; i < int'(BLOCK_WORDS - WORDS_PER_CYCLE); i++) begin
            window_shift[i] = window_q[i + int'(WORDS_PER_CYCLE)];
        end
        for (int j = 0; j < int'(WORDS_PER_CYCLE); j++) begin
            window_shift[int'(BLOCK_WORDS - WORDS_PER_CYCLE) + j] = new_lo[j] | new_hi[j];
        end
    end

    // ------------------------------------------------------------------
    // Control FSM and datapath registers.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            t_q      <= '0;
            window_q <= '0;
`ifdef SHA256_SCHED_DBL_BUF_EN
            shadow_q      <= '0;
            shadow_full_q <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_fire) begin
                        window_q <= block_to_window(in_block);
                        t_q      <= '0;
                        state_q  <= StRun;
                    end
                end

                StRun: begin
`ifdef SHA256_SCHED_DBL_BUF_EN
                    // A block arriving on the final beat bypasses the shadow.
                    if (in_fire && !(out_fire && w_last)) begin
                        shadow_q      <= in_block;
                        shadow_full_q <= 1'b1;
                    end
`endif
                    if (out_fire) begin
                        if (w_last) begin
`ifdef SHA256_SCHED_DBL_BUF_EN
                            if (shadow_full_q) begin
                                window_q      <= block_to_window(shadow_q);
                                t_q           <= '0;
                                shadow_full_q <= 1'b0;
                            end else if (in_fire) begin
                                window_q <= block_to_window(in_block);
                                t_q      <= '0;
                            end else begin
                                state_q <= StIdle;
                            end
`else
                            state_q <= StIdle;
`endif
                        end else begin
                            window_q <= window_shift;
                            t_q      <= t_q + STEP;
                        end
                    end
                end

                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_sha256_msg_schedule.sv
// tb_sha256_msg_schedule
//   Self-checking bench for sha256_msg_schedule (WORDS_PER_CYCLE = 4).
//   Expected schedule words come from a plain 64-entry recurrence model;
//   the "abc" block is additionally checked against fixed known values.
`timescale 1ns/1ps
module tb_sha256_msg_schedule;

    localparam int unsigned WPC   = 4;
    localparam int unsigned IDX_W = 6;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [511:0]      in_block;
    logic              w_valid;
    logic              w_ready;
    logic [32*WPC-1:0] w_data;
    logic [IDX_W-1:0]  w_index;
    logic              w_last;
    logic              busy;

    always #5 clk = ~clk;

    sha256_msg_schedule #(
        .WORDS_PER_CYCLE (WPC),
        .IDX_W           (IDX_W)
    ) u_dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_block (in_block),
        .w_valid  (w_valid),
        .w_ready  (w_ready),
        .w_data   (w_data),
        .w_index  (w_index),
        .w_last   (w_last),
        .busy     (busy)
    );

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] exp_w [128];
    logic [31:0] got_w [64];

    typedef struct {
        string       name;
        int          idx;
        logic [31:0] exp;
    } abc_vec_t;

    // ---------------- reference model ----------------
    function automatic logic [31:0] rr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] ref_s0(input logic [31:0] x);
        return rr(x, 7) ^ rr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ref_s1(input logic [31:0] x);
        return rr(x, 17) ^ rr(x, 19) ^ (x >> 10);
    endfunction

    task automatic model_block(input logic [511:0] blk, input int base);
        logic [31:0] w [64];
        for (int i = 0; i < 16; i++) w[i] = blk[511 - 32*i -: 32];
        for (int i = 16; i < 64; i++)
            w[i] = ref_s1(w[i-2]) + w[i-7] + ref_s0(w[i-15]) + w[i-16];
        for (int i = 0; i < 64; i++) exp_w[base + i] = w[i];
    endtask

    function automatic logic [511:0] rand_block();
        logic [511:0] b;
        for (int i = 0; i < 16; i++) b[32*i +: 32] = $urandom;
        return b;
    endfunction

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
        end
    endtask

    task automatic load_block(input logic [511:0] blk);
        int n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("load_in_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_block = blk;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Follows nblk blocks of expected words in exp_w. Optionally holds junk on
    // the input during the run, or offers blk2 at the start of the run.
    task automatic run_stream(input int nblk, input int stall_pct, input bit hold_junk,
                              input bit send2, input logic [511:0] blk2);
        int                pos     = 0;
        int                total   = 64 * nblk;
        bit                stalled = 1'b0;
        bit                pend    = send2;
        logic [32*WPC-1:0] held_d  = '0;
        logic [IDX_W-1:0]  held_i  = '0;
        logic [511:0]      junk    = rand_block();
        for (int cyc = 0; cyc < 4000 && pos < total; cyc++) begin
            w_ready = ($urandom_range(99) >= stall_pct);
            if (pend) begin
                in_valid = 1'b1;
                in_block = blk2;
            end else if (hold_junk) begin
                in_valid = 1'b1;
                in_block = junk;
            end
            @(negedge clk);
            chk("w_valid_run", 32'(w_valid), 32'd1);
            chk("busy_run", 32'(busy), 32'd1);
            if (hold_junk) chk("in_ready_run", 32'(in_ready), 32'd0);
            if (stalled) begin
                chk("stall_index", 32'(w_index), 32'(held_i));
                for (int k = 0; k < int'(WPC); k++)
                    chk("stall_data", w_data[32*k +: 32], held_d[32*k +: 32]);
            end
            chk("w_index", 32'(w_index), 32'(pos % 64));
            chk("w_last", 32'(w_last), 32'((pos % 64) == int'(64 - WPC)));
            for (int k = 0; k < int'(WPC); k++) begin
                got_w[(pos + k) % 64] = w_data[32*k +: 32];
                chk("w_data", w_data[32*k +: 32], exp_w[pos + k]);
            end
            if (pend && in_ready) pend = 1'b0;
            if (w_valid && w_ready) begin
                pos     += int'(WPC);
                stalled = 1'b0;
            end else begin
                stalled = 1'b1;
                held_d  = w_data;
                held_i  = w_index;
            end
            @(posedge clk); #1;
            in_valid = 1'b0;
        end
        if (pos < total) begin
            n_vec++;
            n_err++;
            $display("FAIL stream_timeout: got %0d words, required %0d", pos, total);
        end
    endtask

    task automatic check_idle();
        @(negedge clk);
        chk("idle_w_valid", 32'(w_valid), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        chk({tag, "_w_valid"}, 32'(w_valid), 32'd0);
        chk({tag, "_w_last"}, 32'(w_last), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_w_index"}, 32'(w_index), 32'd0);
        for (int k = 0; k < int'(WPC); k++)
            chk({tag, "_w_data"}, w_data[32*k +: 32], 32'd0);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        abc_vec_t     abc_tab [7];
        logic [511:0] abc_blk;
        logic [511:0] blk_a;
        logic [511:0] blk_b;

        abc_blk    = {32'h61626380, 448'h0, 32'h00000018};
        abc_tab[0] = '{"abc_w0",  0,  32'h61626380};
        abc_tab[1] = '{"abc_w1",  1,  32'h00000000};
        abc_tab[2] = '{"abc_w15", 15, 32'h00000018};
        abc_tab[3] = '{"abc_w16", 16, 32'h61626380};
        abc_tab[4] = '{"abc_w17", 17, 32'h000F0000};
        abc_tab[5] = '{"abc_w18", 18, 32'h7DA86405};
        abc_tab[6] = '{"abc_w63", 63, 32'h12B1EDEB};

        reset    = 1'b1;
        in_valid = 1'b0;
        in_block = '0;
        w_ready  = 1'b0;

        // Reset state.
        #12;
        check_all_zero("reset");
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("post_reset_in_ready", 32'(in_ready), 32'd1);
        chk("post_reset_w_valid", 32'(w_valid), 32'd0);
        @(posedge clk); #1;

        // "abc" block, no backpressure, plus known-value table.
        model_block(abc_blk, 0);
        load_block(abc_blk);
        run_stream(1, 0, 1'b0, 1'b0, '0);
        check_idle();
        for (int i = 0; i < 7; i++)
            chk(abc_tab[i].name, got_w[abc_tab[i].idx], abc_tab[i].exp);

        // Random blocks under 50% backpressure.
        for (int b = 0; b < 3; b++) begin
            blk_a = rand_block();
            model_block(blk_a, 0);
            load_block(blk_a);
            run_stream(1, 50, 1'b0, 1'b0, '0);
            check_idle();
        end

`ifdef SHA256_SCHED_DBL_BUF_EN
        // Two blocks back-to-back: w_valid must stay high across the seam.
        blk_a = rand_block();
        blk_b = rand_block();
        model_block(blk_a, 0);
        model_block(blk_b, 64);
        load_block(blk_a);
        run_stream(2, 0, 1'b0, 1'b1, blk_b);
        check_idle();
`else
        // New block offered throughout a run must be refused and ignored.
        blk_a = rand_block();
        blk_b = '0;
        model_block(blk_a, 0);
        load_block(blk_a);
        run_stream(1, 25, 1'b1, 1'b0, blk_b);
        check_idle();
`endif

        // Reset in the middle of a block, then a fresh block from W0.
        blk_a = rand_block();
        load_block(blk_a);
        w_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
        end
        chk("mid_w_index", 32'(w_index), 32'(5 * WPC));
        #2;
        reset = 1'b1;
        #1;
        check_all_zero("abort");
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        blk_a = rand_block();
        model_block(blk_a, 0);
        load_block(blk_a);
        run_stream(1, 30, 1'b0, 1'b0, '0);
        check_idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
